// File: rtl/display_mode_mux_if.sv
// Video-in / video-out bundle for display_mode_mux.
// The master side drives sync, controls and pixel buses; the slave side returns the selected pixel.
interface display_mode_mux_if;
    logic        i_posterize_en;
    logic [1:0]  i_display_sel;
    logic        i_vs;
    logic        i_hs;
    logic        i_de;
    logic [23:0] i_raw_data;
    logic [23:0] i_sobel_data;
    logic        o_vs;
    logic        o_hs;
    logic        o_de;
    logic [23:0] o_data;
    logic [1:0]  o_mode;

    modport master (
        output i_posterize_en, i_display_sel, i_vs, i_hs, i_de, i_raw_data, i_sobel_data,
        input  o_vs, o_hs, o_de, o_data, o_mode
    );

    modport slave (
        input  i_posterize_en, i_display_sel, i_vs, i_hs, i_de, i_raw_data, i_sobel_data,
        output o_vs, o_hs, o_de, o_data, o_mode
    );
endinterface

// File: rtl/display_mode_mux.sv
// Per-pixel choice of raw, Sobel, half-split or posterized video; mode is latched only at vsync rise.
// Define SPLIT_LINE_EN to draw a white divider column in the half-split modes.
module display_mode_mux #(
    parameter int H_ACTIVE  = 640,
    parameter int COL_WIDTH = 11,
    parameter int P_BITS    = 2
) (
    input  logic              i_pclk,
    input  logic              i_srst,
    display_mode_mux_if.slave bus
);
    // state            | meaning
    // MODE_RAW         | raw pixels on the whole screen (also after reset)
    // MODE_FULL_SOBEL  | Sobel pixels on the whole screen
    // MODE_HALF_SOBEL  | Sobel on the left half, raw on the right half
    // MODE_HALF_POST   | posterized raw on the left half, raw on the right half
    typedef enum logic [1:0] {
        MODE_RAW        = 2'd0,
        MODE_FULL_SOBEL = 2'd1,
        MODE_HALF_SOBEL = 2'd2,
        MODE_HALF_POST  = 2'd3
    } mode_t;

    localparam logic [COL_WIDTH-1:0] COL_SPLIT = COL_WIDTH'(H_ACTIVE / 2);
    localparam logic [COL_WIDTH-1:0] COL_MAX   = '1;

    mode_t                r_mode;
    mode_t                mode_next;
    mode_t                mode_dec;
    logic                 vs_d1;
    logic                 vs_rise;
    logic [COL_WIDTH-1:0] r_col;

    logic                 vs1, hs1, de1, left1;
    logic [23:0]          raw1, sobel1;
    mode_t                mode1;
`ifdef SPLIT_LINE_EN
    logic                 split1;
`endif
    logic [23:0]          pix_sel;

    function automatic logic [7:0] post_chan(input logic [7:0] c);
        logic [7:0] r;
        r = '0;
        for (int i = 0; i < 8; i++) begin
            r[7-i] = c[7 - (i % P_BITS)];
        end
        return r;
    endfunction

    always_comb begin
        mode_dec = MODE_RAW;
        case ({bus.i_posterize_en, bus.i_display_sel})
            3'b100:  mode_dec = MODE_RAW;
            3'b101:  mode_dec = MODE_FULL_SOBEL;
            3'b110:  mode_dec = MODE_HALF_SOBEL;
            3'b000:  mode_dec = MODE_HALF_POST;
            default: mode_dec = MODE_RAW;
        endcase
        vs_rise   = bus.i_vs & ~vs_d1;
        mode_next = vs_rise ? mode_dec : r_mode;
    end

    always_ff @(posedge i_pclk) begin
        if (i_srst) begin
            r_mode <= MODE_RAW;
            vs_d1  <= 1'b0;
            r_col  <= '0;
        end else begin
            r_mode <= mode_next;
            vs_d1  <= bus.i_vs;
            if (!bus.i_de) begin
                r_col <= '0;
            end else if (r_col != COL_MAX) begin
                r_col <= r_col + 1'b1;
            end
        end
    end

    // Stage 1 carries the mode being loaded this cycle, so a pixel on the vs-rise cycle already uses it.
    always_ff @(posedge i_pclk) begin
        if (i_srst) begin
            vs1    <= 1'b0;
            hs1    <= 1'b0;
            de1    <= 1'b0;
            left1  <= 1'b0;
            raw1   <= '0;
            sobel1 <= '0;
            mode1  <= MODE_RAW;
        end else begin
            vs1    <= bus.i_vs;
            hs1    <= bus.i_hs;
            de1    <= bus.i_de;
            left1  <= (r_col < COL_SPLIT);
            raw1   <= bus.i_raw_data;
            sobel1 <= bus.i_sobel_data;
            mode1  <= mode_next;
        end
    end

`ifdef SPLIT_LINE_EN
    always_ff @(posedge i_pclk) begin
        if (i_srst) begin
            split1 <= 1'b0;
        end else begin
            split1 <= (r_col == COL_SPLIT);
        end
    end
`endif

    always_comb begin
        pix_sel = raw1;
        case (mode1)
            MODE_FULL_SOBEL: pix_sel = sobel1;
            MODE_HALF_SOBEL: pix_sel = left1 ? sobel1 : raw1;
            MODE_HALF_POST:  pix_sel = left1 ? {post_chan(raw1[23:16]), post_chan(raw1[15:8]),
                                                post_chan(raw1[7:0])} : raw1;
            default:         pix_sel = raw1;
        endcase
`ifdef SPLIT_LINE_EN
        if (split1 && (mode1 == MODE_HALF_SOBEL || mode1 == MODE_HALF_POST)) begin
            pix_sel = 24'hFFFFFF;
        end
`endif
    end

    always_ff @(posedge i_pclk) begin
        if (i_srst) begin
            bus.o_vs   <= 1'b0;
            bus.o_hs   <= 1'b0;
            bus.o_de   <= 1'b0;
            bus.o_data <= '0;
            bus.o_mode <= 2'd0;
        end else begin
            bus.o_vs   <= vs1;
            bus.o_hs   <= hs1;
            bus.o_de   <= de1;
            bus.o_data <= de1 ? pix_sel : 24'h0;
            bus.o_mode <= mode1;
        end
    end
endmodule

// File: tb/tb_display_mode_mux.sv
// Randomized bench for display_mode_mux: per-cycle compare against a rule-level model,
// plus directed frames with literal expectations.
module tb_display_mode_mux;
    localparam int H_ACTIVE = 640;
    localparam int COL_MAX  = 2047;
    localparam int P_BITS   = 2;
`ifdef SPLIT_LINE_EN
    localparam logic [23:0] DIV_PIX = 24'hFFFFFF;
`else
    localparam logic [23:0] DIV_PIX = 24'h123456;
`endif

    logic pclk;
    logic srst;
    display_mode_mux_if bus ();

    display_mode_mux dut (
        .i_pclk (pclk),
        .i_srst (srst),
        .bus    (bus)
    );

    initial begin
        pclk = 1'b0;
        forever #5 pclk = ~pclk;
    end

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // ---------------- reference model ----------------
    typedef struct packed {
        logic        vs;
        logic        hs;
        logic        de;
        logic [1:0]  mode;
        logic [23:0] data;
    } out_t;

    out_t        stage_m, exp_out;
    int          col_m;
    logic        prev_vs_m;
    logic [1:0]  mode_m;
    bit          armed = 0;

    // Take the top P_BITS bits and repeat that pattern until 8 bits are filled.
    function automatic logic [7:0] m_post(input logic [7:0] c);
        int top, acc, n;
        top = int'(c) >> (8 - P_BITS);
        acc = 0;
        n   = 0;
        while (n < 8) begin
            acc = (acc << P_BITS) | top;
            n  += P_BITS;
        end
        return 8'(acc >> (n - 8));
    endfunction

    function automatic logic [1:0] m_decode(input logic [2:0] code);
        case (code)
            3'b101:  return 2'd1;
            3'b110:  return 2'd2;
            3'b000:  return 2'd3;
            default: return 2'd0;
        endcase
    endfunction

    function automatic logic [23:0] m_pixel(input logic [1:0] mode, input int col,
                                            input logic [23:0] raw, input logic [23:0] sob);
        bit left;
        left = (col < H_ACTIVE / 2);
`ifdef SPLIT_LINE_EN
        if ((mode == 2'd2 || mode == 2'd3) && col == H_ACTIVE / 2) return 24'hFFFFFF;
`endif
        case (mode)
            2'd1:    return sob;
            2'd2:    return left ? sob : raw;
            2'd3:    return left ? {m_post(raw[23:16]), m_post(raw[15:8]), m_post(raw[7:0])} : raw;
            default: return raw;
        endcase
    endfunction

    always @(posedge pclk) begin
        if (srst) begin
            exp_out   = '0;
            stage_m   = '0;
            mode_m    = 2'd0;
            prev_vs_m = 1'b0;
            col_m     = 0;
            armed     = 1;
        end else begin
            exp_out = stage_m;
            if (bus.i_vs && !prev_vs_m)
                mode_m = m_decode({bus.i_posterize_en, bus.i_display_sel});
            prev_vs_m     = bus.i_vs;
            stage_m.vs    = bus.i_vs;
            stage_m.hs    = bus.i_hs;
            stage_m.de    = bus.i_de;
            stage_m.mode  = mode_m;
            stage_m.data  = bus.i_de ? m_pixel(mode_m, col_m, bus.i_raw_data, bus.i_sobel_data) : 24'h0;
            if (!bus.i_de)          col_m = 0;
            else if (col_m < COL_MAX) col_m = col_m + 1;
        end
    end

    always @(negedge pclk) begin
        if (armed)
            check("pipe", 32'({bus.o_vs, bus.o_hs, bus.o_de, bus.o_mode, bus.o_data}), 32'(exp_out));
    end

    // ---------------- stimulus ----------------
    task automatic set_ctrl(input logic [2:0] c);
        bus.i_posterize_en = c[2];
        bus.i_display_sel  = c[1:0];
    endtask

    task automatic vs_pulse(input logic [2:0] c);
        set_ctrl(c);
        bus.i_vs = 1'b1;
        repeat (2) @(negedge pclk);
        bus.i_vs = 1'b0;
        repeat (3) @(negedge pclk);
    endtask

    task automatic rand_line(input int len);
        bus.i_hs = 1'b1;
        repeat (2) @(negedge pclk);
        bus.i_hs = 1'b0;
        bus.i_raw_data = 24'($urandom);
        repeat (3) @(negedge pclk);
        for (int k = 0; k < len; k++) begin
            bus.i_de         = 1'b1;
            bus.i_raw_data   = 24'($urandom);
            bus.i_sobel_data = 24'($urandom);
            if ($urandom_range(0, 63) == 0) set_ctrl(3'($urandom_range(0, 7)));
            @(negedge pclk);
        end
        bus.i_de       = 1'b0;
        bus.i_raw_data = 24'($urandom);
        repeat (4) @(negedge pclk);
    endtask

    // Output for column c is visible at the end of loop iteration c+1.
    task automatic fixed_line(input int len, input logic [23:0] raw, input logic [23:0] sob,
                              input int ca, input logic [23:0] ea,
                              input int cb, input logic [23:0] eb,
                              input int cc, input logic [23:0] ec);
        bus.i_raw_data   = raw;
        bus.i_sobel_data = sob;
        repeat (2) @(negedge pclk);
        for (int k = 0; k < len; k++) begin
            bus.i_de = 1'b1;
            @(negedge pclk);
            if (k == ca + 1) check($sformatf("col%0d", ca), 32'(bus.o_data), 32'(ea));
            if (k == cb + 1) check($sformatf("col%0d", cb), 32'(bus.o_data), 32'(eb));
            if (k == cc + 1) check($sformatf("col%0d", cc), 32'(bus.o_data), 32'(ec));
        end
        bus.i_de = 1'b0;
        repeat (4) @(negedge pclk);
    endtask

    initial begin
        srst = 1'b1;
        set_ctrl(3'b100);
        bus.i_vs = 1'b0;
        bus.i_hs = 1'b0;
        bus.i_de = 1'b0;
        bus.i_raw_data   = '0;
        bus.i_sobel_data = '0;

        check("m_post_C5", 32'(m_post(8'hC5)), 32'h0000_00FF);
        check("m_post_45", 32'(m_post(8'h45)), 32'h0000_0055);
        check("m_pixel_post", 32'(m_pixel(2'd3, 0, 24'hC54580, 24'h0)), 32'h00FF_55AA);

        repeat (3) @(negedge pclk);
        check("reset_data", 32'(bus.o_data), 32'h0);
        check("reset_mode", 32'(bus.o_mode), 32'h0);
        srst = 1'b0;

        // raw pass-through straight after reset
        bus.i_raw_data   = 24'h123456;
        bus.i_sobel_data = 24'hABCDEF;
        bus.i_de         = 1'b1;
        repeat (3) @(negedge pclk);
        check("t1_data", 32'(bus.o_data), 32'h0012_3456);
        check("t1_mode", 32'(bus.o_mode), 32'h0);
        bus.i_de = 1'b0;
        repeat (4) @(negedge pclk);

        // control change mid-frame takes effect only at the next vs rise
        vs_pulse(3'b100);
        set_ctrl(3'b101);
        fixed_line(200, 24'h123456, 24'hABCDEF, 10, 24'h123456, 150, 24'h123456, -5, 24'h0);
        check("t2_mode_hold", 32'(bus.o_mode), 32'h0);
        vs_pulse(3'b101);
        fixed_line(50, 24'h123456, 24'hABCDEF, 5, 24'hABCDEF, -5, 24'h0, -5, 24'h0);
        check("t2_mode_new", 32'(bus.o_mode), 32'h1);

        // half Sobel split
        vs_pulse(3'b110);
        fixed_line(640, 24'h123456, 24'hABCDEF, 319, 24'hABCDEF, 320, DIV_PIX, 321, 24'h123456);

        // half posterize
        vs_pulse(3'b000);
        fixed_line(640, 24'hC54580, 24'hABCDEF, 0, 24'hFF55AA, 319, 24'hFF55AA, 500, 24'hC54580);
        check("t4_mode", 32'(bus.o_mode), 32'h3);

        // unused code falls back to raw; long line does not wrap
        vs_pulse(3'b111);
        fixed_line(700, 24'h123456, 24'hABCDEF, 0, 24'h123456, 650, 24'h123456, 698, 24'h123456);
        check("t5_mode", 32'(bus.o_mode), 32'h0);

        // reset mid-line in full Sobel
        vs_pulse(3'b101);
        bus.i_raw_data   = 24'h123456;
        bus.i_sobel_data = 24'hABCDEF;
        for (int k = 0; k < 200; k++) begin
            bus.i_de = 1'b1;
            srst = (k == 100);
            @(negedge pclk);
            if (k == 50)  check("t6_pre", 32'(bus.o_data), 32'h00AB_CDEF);
            if (k == 100) check("t6_rst_out", 32'({bus.o_de, bus.o_data}), 32'h0);
            if (k == 110) check("t6_raw", 32'(bus.o_data), 32'h0012_3456);
            if (k == 110) check("t6_mode", 32'(bus.o_mode), 32'h0);
        end
        srst = 1'b0;
        bus.i_de = 1'b0;
        repeat (4) @(negedge pclk);

        // randomized frames
        for (int f = 0; f < 14; f++) begin
            vs_pulse(3'($urandom_range(0, 7)));
            rand_line(($urandom_range(0, 3) == 0) ? 700 : int'($urandom_range(1, 700)));
            rand_line(int'($urandom_range(300, 700)));
        end

        repeat (4) @(negedge pclk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
